// File: rtl/trap_control_fsm_if.sv
// rtl/trap_control_fsm_if.sv - stage-2 trap sequencer signal bundle (decoder/IRQ side in, trap control out)
interface trap_control_fsm_if #(
    parameter int XLEN = 32
);
    logic            instr_valid_in;
    logic [XLEN-1:0] pc_in;
    logic            illegal_instr_in;
    logic            misaligned_instr_in;
    logic            misaligned_load_in;
    logic            misaligned_store_in;
    logic            ecall_in;
    logic            ebreak_in;
    logic            mret_in;
    logic            wfi_in;
    logic            mie_in;
    logic            meie_in;
    logic            mtie_in;
    logic            ext_irq_in;
    logic            timer_irq_in;

    logic            trap_taken_out;
    logic            flush_out;
    logic            stall_out;
    logic [1:0]      pc_src_out;
    logic [XLEN-1:0] mepc_out;
    logic [XLEN-1:0] mcause_out;
    logic            mepc_wr_en_out;
    logic            mcause_wr_en_out;
    logic            mie_clear_out;
    logic            mie_set_out;

    modport master (
        output instr_valid_in, pc_in, illegal_instr_in, misaligned_instr_in,
               misaligned_load_in, misaligned_store_in, ecall_in, ebreak_in,
               mret_in, wfi_in, mie_in, meie_in, mtie_in, ext_irq_in, timer_irq_in,
        input  trap_taken_out, flush_out, stall_out, pc_src_out, mepc_out, mcause_out,
               mepc_wr_en_out, mcause_wr_en_out, mie_clear_out, mie_set_out
    );

    modport slave (
        input  instr_valid_in, pc_in, illegal_instr_in, misaligned_instr_in,
               misaligned_load_in, misaligned_store_in, ecall_in, ebreak_in,
               mret_in, wfi_in, mie_in, meie_in, mtie_in, ext_irq_in, timer_irq_in,
        output trap_taken_out, flush_out, stall_out, pc_src_out, mepc_out, mcause_out,
               mepc_wr_en_out, mcause_wr_en_out, mie_clear_out, mie_set_out
    );
endinterface

// File: rtl/trap_control_fsm.sv
// rtl/trap_control_fsm.sv - machine-mode trap/MRET/WFI sequencer with registered Moore outputs
module trap_control_fsm #(
    parameter int XLEN       = 32,
    parameter int RESET_HOLD = 2
) (
    input logic               clk_in,
    input logic               rst_n_in,
    trap_control_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        ST_RESET, ST_OPERATING, ST_TRAP_TAKEN, ST_TRAP_RETURN, ST_WAIT_IRQ
    } state_t;

    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

    state_t          r_state;
    logic [HW-1:0]   r_hold_cnt;
    logic            r_trap_taken, r_flush, r_stall, r_mepc_wr, r_mcause_wr, r_mie_clear, r_mie_set;
    logic [1:0]      r_pc_src;
    logic [XLEN-1:0] r_mepc, r_mcause;

    state_t          w_next;
    logic            w_exc, w_irq_ext, w_irq_tmr, w_irq_any, w_cap, w_cap_irq;
    logic [3:0]      w_exc_code, w_irq_code, w_cap_code;
    logic [XLEN-1:0] w_cap_pc, w_pc_plus4;

    assign w_irq_ext  = bus.ext_irq_in & bus.meie_in;
    assign w_irq_tmr  = bus.timer_irq_in & bus.mtie_in;
    assign w_irq_any  = w_irq_ext | w_irq_tmr;
    assign w_irq_code = w_irq_ext ? 4'd11 : 4'd7;
    assign w_pc_plus4 = bus.pc_in + XLEN'(4);

    // Synchronous exceptions in fixed priority; first match supplies the cause code
    always_comb begin
        w_exc      = 1'b1;
        w_exc_code = 4'd0;
        if (bus.misaligned_instr_in)      w_exc_code = 4'd0;
        else if (bus.illegal_instr_in)    w_exc_code = 4'd2;
        else if (bus.ebreak_in)           w_exc_code = 4'd3;
        else if (bus.ecall_in)            w_exc_code = 4'd11;
        else if (bus.misaligned_load_in)  w_exc_code = 4'd4;
        else if (bus.misaligned_store_in) w_exc_code = 4'd6;
        else                              w_exc      = 1'b0;
    end

    always_comb begin
        w_next     = r_state;
        w_cap      = 1'b0;
        w_cap_irq  = 1'b0;
        w_cap_code = 4'd0;
        w_cap_pc   = bus.pc_in;
        case (r_state)
            ST_RESET: if (r_hold_cnt == HOLD_LAST) w_next = ST_OPERATING;
            ST_OPERATING: begin
                if (bus.instr_valid_in) begin
                    if (w_exc) begin
                        w_cap      = 1'b1;
                        w_cap_code = w_exc_code;
                    end else if (bus.mie_in && w_irq_any) begin
                        w_cap      = 1'b1;
                        w_cap_irq  = 1'b1;
                        w_cap_code = w_irq_code;
                    end else if (bus.mret_in) begin
                        w_next = ST_TRAP_RETURN;
                    end else if (bus.wfi_in) begin
                        w_next = ST_WAIT_IRQ;
                    end
                end
            end
            ST_TRAP_TAKEN, ST_TRAP_RETURN: w_next = ST_OPERATING;
            // Wake-up ignores MIE; only the trap decision depends on it
            ST_WAIT_IRQ: begin
                if (w_irq_any) begin
                    if (bus.mie_in) begin
                        w_cap      = 1'b1;
                        w_cap_irq  = 1'b1;
                        w_cap_code = w_irq_code;
                        w_cap_pc   = w_pc_plus4;
                    end else begin
                        w_next = ST_OPERATING;
                    end
                end
            end
            default: w_next = ST_RESET;
        endcase
        if (w_cap) w_next = ST_TRAP_TAKEN;
    end

    // Outputs are registered from the next state so they line up with r_state
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= ST_RESET;
            r_hold_cnt   <= '0;
            r_trap_taken <= 1'b0;
            r_flush      <= 1'b1;
            r_stall      <= 1'b0;
            r_pc_src     <= 2'b00;
            r_mepc_wr    <= 1'b0;
            r_mcause_wr  <= 1'b0;
            r_mie_clear  <= 1'b0;
            r_mie_set    <= 1'b0;
            r_mepc       <= '0;
            r_mcause     <= '0;
        end else begin
            r_state      <= w_next;
            r_hold_cnt   <= (r_state == ST_RESET) ? r_hold_cnt + HW'(1) : '0;
            r_trap_taken <= (w_next == ST_TRAP_TAKEN);
            r_flush      <= (w_next == ST_RESET) || (w_next == ST_TRAP_TAKEN) || (w_next == ST_TRAP_RETURN);
            r_stall      <= (w_next == ST_WAIT_IRQ);
            r_mepc_wr    <= (w_next == ST_TRAP_TAKEN);
            r_mcause_wr  <= (w_next == ST_TRAP_TAKEN);
            r_mie_clear  <= (w_next == ST_TRAP_TAKEN);
            r_mie_set    <= (w_next == ST_TRAP_RETURN);
            case (w_next)
                ST_RESET:       r_pc_src <= 2'b00;
                ST_TRAP_TAKEN:  r_pc_src <= 2'b01;
                ST_TRAP_RETURN: r_pc_src <= 2'b10;
                default:        r_pc_src <= 2'b11;
            endcase
            if (w_cap) begin
                r_mepc   <= w_cap_pc;
                r_mcause <= {w_cap_irq, {(XLEN-5){1'b0}}, w_cap_code};
            end
        end
    end

    assign bus.trap_taken_out   = r_trap_taken;
    assign bus.flush_out        = r_flush;
    assign bus.stall_out        = r_stall;
    assign bus.pc_src_out       = r_pc_src;
    assign bus.mepc_out         = r_mepc;
    assign bus.mcause_out       = r_mcause;
    assign bus.mepc_wr_en_out   = r_mepc_wr;
    assign bus.mcause_wr_en_out = r_mcause_wr;
    assign bus.mie_clear_out    = r_mie_clear;
    assign bus.mie_set_out      = r_mie_set;
endmodule
